// File: rtl/instr_prefetch_unit_pkg.sv
// Shared widths and the queue entry type for the instruction fetch stage.
// Architectural widths live here so every file of the fetch stage agrees.
package instr_prefetch_unit_pkg;

   localparam int INSTR_WIDTH = 32;
   localparam int PC_WIDTH    = 32;
   localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0;

   // One buffered fetch: the instruction word and the address it came from.
   typedef struct packed {
      logic [INSTR_WIDTH-1:0] instr;
      logic [PC_WIDTH-1:0]    pc;
   } fetch_entry_t;

endpackage

// File: rtl/instr_prefetch_unit_fetch_queue.sv
// fetch_queue: circular buffer of {instr, pc} entries for the prefetch stage.
// Flush clears pointers and count and takes priority over push and pop.
// The caller guarantees no push when full (unless popping) and no pop when empty.
module fetch_queue
   import instr_prefetch_unit_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  fetch_entry_t           push_data,
   input  logic                   pop,
   input  logic                   flush,
   output logic [$clog2(DEPTH):0] count,
   output fetch_entry_t           head
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] cnt;

   // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Entry storage; contents need no reset because count gates their visibility.
   always_ff @(posedge clk) begin
      if (push && !flush && !rst) mem[wr_ptr] <= push_data;
   end

   assign count = cnt;
   assign head  = mem[rd_ptr];

endmodule

// File: rtl/instr_prefetch_unit.sv
// instr_prefetch_unit: owns the fetch PC, reads imem port 0 every cycle and
// buffers {instr, pc} in a fetch_queue that decode drains.
// Optional macro FETCH_BYPASS_EN: when the queue is empty and no redirect is
// pending, the word being fetched is presented to decode in the same cycle.
//
// Handshake: decode takes the head on a cycle where instr_valid and issue_ready
// are both high; instr_valid never depends on issue_ready, and the head is
// stable until taken or flushed. A redirect in the same cycle as a completed
// handshake still counts the head as issued, then flushes everything behind it.
module instr_prefetch_unit
   import instr_prefetch_unit_pkg::*;
#(
   parameter int                  DEPTH    = 4,
   parameter logic [PC_WIDTH-1:0] RESET_PC = 32'h0
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic [PC_WIDTH-1:0]    imem_addr,
   input  logic [INSTR_WIDTH-1:0] imem_data,
   input  logic                   redirect_valid,
   input  logic [PC_WIDTH-1:0]    redirect_pc,
   output logic                   instr_valid,
   output logic [INSTR_WIDTH-1:0] instr_out,
   output logic [PC_WIDTH-1:0]    instr_pc,
   input  logic                   issue_ready,
   output logic [PC_WIDTH-1:0]    fetch_pc,
   output logic [$clog2(DEPTH):0] queue_count
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [PC_WIDTH-1:0] pc_q;
   logic [CW-1:0]       q_count;
   fetch_entry_t        q_head;
   fetch_entry_t        last_q;
   fetch_entry_t        shown;
   logic                queue_valid;
   logic                bypass_take;
   logic                pop;
   logic                push;
   logic                advance;

   fetch_queue #(.DEPTH(DEPTH)) u_queue (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data ('{instr: imem_data, pc: pc_q}),
      .pop       (pop),
      .flush     (redirect_valid),
      .count     (q_count),
      .head      (q_head)
   );

   // Head presentation, optional same-cycle bypass, and the push/pop decision.
   always_comb begin
      queue_valid = (q_count != '0);
      bypass_take = 1'b0;
`ifdef FETCH_BYPASS_EN
      if (queue_valid) begin
         instr_valid = 1'b1;
         shown       = q_head;
      end else if (!redirect_valid) begin
         instr_valid = 1'b1;
         shown       = '{instr: imem_data, pc: pc_q};
         bypass_take = issue_ready;
      end else begin
         instr_valid = 1'b0;
         shown       = last_q;
      end
`else
      instr_valid = queue_valid;
      shown       = queue_valid ? q_head : last_q;
`endif
      pop     = queue_valid && issue_ready;
      push    = !redirect_valid && !bypass_take && ((q_count < CW'(DEPTH)) || pop);
      advance = push || bypass_take;
   end

   // Fetch PC: reset, then redirect target, else step one word per consumed fetch.
   always_ff @(posedge clk) begin
      if (rst)                 pc_q <= RESET_PC;
      else if (redirect_valid) pc_q <= redirect_pc;
      else if (advance)        pc_q <= pc_q + PC_WIDTH'(1);
   end

   // Remember the last presented entry so the outputs hold while empty.
   always_ff @(posedge clk) begin
      if (rst)              last_q <= '{instr: NOP_INSTR, pc: '0};
      else if (instr_valid) last_q <= shown;
   end

   assign instr_out   = shown.instr;
   assign instr_pc    = shown.pc;
   assign imem_addr   = pc_q;
   assign fetch_pc    = pc_q;
   assign queue_count = q_count;

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Self-checking bench for instr_prefetch_unit (default build, DEPTH=4).
module tb_instr_prefetch_unit;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0;
   localparam logic [31:0] MEM_BASE = 32'hA000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        instr_valid;
   logic [31:0] instr_out;
   logic [31:0] instr_pc;
   logic        issue_ready = 1'b0;
   logic [31:0] fetch_pc;
   logic [2:0]  queue_count;

   int checks   = 0;
   int failures = 0;

   // reference model state
   logic [31:0] exp_q[$];
   logic [31:0] issued_q[$];
   logic [31:0] m_pc;
   logic [31:0] m_last_pc;
   logic [31:0] m_last_instr;

   // clock / reset block
   always #5 clk = ~clk;

   // memory model: mem[a] = A000_0000 + a
   assign imem_data = MEM_BASE + imem_addr;

   instr_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_out      (instr_out),
      .instr_pc       (instr_pc),
      .issue_ready    (issue_ready),
      .fetch_pc       (fetch_pc),
      .queue_count    (queue_count)
   );

   function automatic void model_reset();
      exp_q.delete();
      m_pc         = RESET_PC;
      m_last_pc    = 32'h0;
      m_last_instr = 32'h0;
   endfunction

   // driver + scoreboard: called #1 after a rising edge; compares the
   // current outputs against the model, then advances one cycle
   task automatic drive_cycle(input logic rdy, input logic rv, input logic [31:0] rpc,
                              input logic r);
      logic        exp_valid;
      logic [31:0] exp_pc_out;
      logic [31:0] exp_instr_out;
      logic        do_pop;
      logic        do_push;
      rst            = r;
      issue_ready    = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      #1;
      exp_valid     = (exp_q.size() != 0);
      exp_pc_out    = exp_valid ? exp_q[0] : m_last_pc;
      exp_instr_out = exp_valid ? (MEM_BASE + exp_q[0]) : m_last_instr;
      checks++;
      if (instr_valid !== exp_valid) begin
         failures++;
         $display("FAIL cyc_valid t=%0t got=%0b exp=%0b", $time, instr_valid, exp_valid);
      end
      checks++;
      if (instr_pc !== exp_pc_out || instr_out !== exp_instr_out) begin
         failures++;
         $display("FAIL cyc_head t=%0t got pc=%h instr=%h exp pc=%h instr=%h",
                  $time, instr_pc, instr_out, exp_pc_out, exp_instr_out);
      end
      checks++;
      if (fetch_pc !== m_pc || imem_addr !== m_pc) begin
         failures++;
         $display("FAIL cyc_fetch_pc t=%0t got=%h addr=%h exp=%h", $time, fetch_pc, imem_addr, m_pc);
      end
      checks++;
      if (int'(queue_count) !== exp_q.size()) begin
         failures++;
         $display("FAIL cyc_count t=%0t got=%0d exp=%0d", $time, queue_count, exp_q.size());
      end
      // model update
      if (r) begin
         model_reset();
      end else begin
         do_pop  = exp_valid && rdy;
         do_push = !rv && (exp_q.size() < DEPTH || do_pop);
         if (exp_valid) begin
            m_last_pc    = exp_q[0];
            m_last_instr = MEM_BASE + exp_q[0];
         end
         if (do_pop) issued_q.push_back(exp_q.pop_front());
         if (rv) begin
            exp_q.delete();
            m_pc = rpc;
         end else if (do_push) begin
            exp_q.push_back(m_pc);
            m_pc = m_pc + 32'd1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive_cycle(1'b0, 1'b0, 32'h0, 1'b1);
      rst = 1'b0;
      issued_q.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (instr_valid !== 1'b0 || instr_out !== 32'h0 || instr_pc !== 32'h0) begin
         failures++;
         $display("FAIL reset_outputs got v=%0b instr=%h pc=%h exp 0/0/0", instr_valid, instr_out, instr_pc);
      end
      checks++;
      if (fetch_pc !== RESET_PC || queue_count !== 3'd0) begin
         failures++;
         $display("FAIL reset_state got fetch_pc=%h count=%0d exp %h/0", fetch_pc, queue_count, RESET_PC);
      end
      model_reset();
      rst = 1'b0;
   endtask

   task automatic test_free_run();
      int first_valid;
      do_reset();
      first_valid = -1;
      for (int c = 0; c < 12; c++) begin
         if (first_valid < 0 && instr_valid === 1'b1) first_valid = c;
         drive_cycle(1'b1, 1'b0, 32'h0, 1'b0);
      end
      checks++;
      if (first_valid !== 1) begin
         failures++;
         $display("FAIL free_run_latency got=%0d exp=1", first_valid);
      end
      checks++;
      if (issued_q.size() < 10 || issued_q[0] !== 32'd0 || issued_q[9] !== 32'd9) begin
         failures++;
         $display("FAIL free_run_order got n=%0d exp first 10 pcs 0..9", issued_q.size());
      end
   endtask

   task automatic test_stall();
      int bad;
      do_reset();
      for (int c = 0; c < 10; c++) drive_cycle(1'b0, 1'b0, 32'h0, 1'b0);
      checks++;
      if (queue_count !== 3'd4 || fetch_pc !== 32'd4) begin
         failures++;
         $display("FAIL stall_full got count=%0d fetch_pc=%h exp 4/4", queue_count, fetch_pc);
      end
      for (int c = 0; c < 8; c++) drive_cycle(1'b1, 1'b0, 32'h0, 1'b0);
      bad = 0;
      for (int i = 0; i < 8; i++)
         if (i >= issued_q.size() || issued_q[i] !== 32'(i)) bad++;
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL stall_drain got %0d wrong of 8 issued=%0d exp pcs 0..7 no gaps", bad, issued_q.size());
      end
   endtask

   task automatic test_redirect();
      logic [31:0] flushed[$];
      logic        v1;
      logic        v2;
      int          hits;
      do_reset();
      for (int c = 0; c < 6; c++) drive_cycle(1'b1, 1'b0, 32'h0, 1'b0);
      for (int c = 0; c < 6; c++) drive_cycle(1'b0, 1'b0, 32'h0, 1'b0);
      flushed = exp_q;
      issued_q.delete();
      drive_cycle(1'b0, 1'b1, 32'h100, 1'b0);
      v1 = instr_valid;
      drive_cycle(1'b1, 1'b0, 32'h0, 1'b0);
      v2 = instr_valid;
      for (int c = 0; c < 4; c++) drive_cycle(1'b1, 1'b0, 32'h0, 1'b0);
      checks++;
      if (v1 !== 1'b0 || v2 !== 1'b1) begin
         failures++;
         $display("FAIL redirect_bubble got v(N+1)=%0b v(N+2)=%0b exp 0/1", v1, v2);
      end
      hits = 0;
      foreach (flushed[i]) foreach (issued_q[j]) if (issued_q[j] === flushed[i]) hits++;
      checks++;
      if (issued_q.size() == 0 || issued_q[0] !== 32'h100 || hits != 0) begin
         failures++;
         $display("FAIL redirect_target got first=%h flushed_issued=%0d exp 100/0",
                  issued_q.size() ? issued_q[0] : 32'hx, hits);
      end
   endtask

   task automatic test_redirect_handshake();
      logic [31:0] head_pc;
      int          seen;
      do_reset();
      for (int c = 0; c < 3; c++) drive_cycle(1'b0, 1'b0, 32'h0, 1'b0);
      head_pc = exp_q[0];
      issued_q.delete();
      drive_cycle(1'b1, 1'b1, 32'h200, 1'b0);
      for (int c = 0; c < 4; c++) drive_cycle(1'b1, 1'b0, 32'h0, 1'b0);
      seen = 0;
      foreach (issued_q[i]) if (issued_q[i] === head_pc) seen++;
      checks++;
      if (seen != 1 || issued_q.size() < 2 || issued_q[1] !== 32'h200) begin
         failures++;
         $display("FAIL redirect_handshake got head_issues=%0d next=%h exp 1/200", seen,
                  issued_q.size() > 1 ? issued_q[1] : 32'hx);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      drive_cycle(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
      issued_q.delete();
      for (int c = 0; c < 5; c++) drive_cycle(1'b1, 1'b0, 32'h0, 1'b0);
      checks++;
      if (issued_q.size() < 2 || issued_q[0] !== 32'hFFFF_FFFF || issued_q[1] !== 32'h0) begin
         failures++;
         $display("FAIL pc_wrap got n=%0d exp FFFFFFFF then 00000000", issued_q.size());
      end
   endtask

   task automatic test_rst_mid();
      do_reset();
      for (int c = 0; c < 6; c++) drive_cycle(1'b0, 1'b0, 32'h0, 1'b0);
      drive_cycle(1'b1, 1'b1, 32'h300, 1'b1);
      checks++;
      if (queue_count !== 3'd0 || instr_valid !== 1'b0 || fetch_pc !== RESET_PC) begin
         failures++;
         $display("FAIL rst_mid got count=%0d v=%0b fetch_pc=%h exp 0/0/%h",
                  queue_count, instr_valid, fetch_pc, RESET_PC);
      end
      rst = 1'b0;
   endtask

   task automatic test_random();
      int n_issued;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         drive_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                     $urandom_range(0, 7) == 0 ? 32'hFFFF_FFFE : $urandom, 1'b0);
      end
      n_issued = issued_q.size();
      checks++;
      if (n_issued < 100) begin
         failures++;
         $display("FAIL random_progress got issued=%0d exp >=100", n_issued);
      end
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_stall();
      test_redirect();
      test_redirect_handshake();
      test_wrap();
      test_rst_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
